// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x oversampling 8N1 UART receiver feeding a small FWFT FIFO.
// A 2-of-3 majority vote is taken over samples 7, 8 and 9 of each bit. The
// block rejects false starts, reports framing errors and reports overruns.
// The consumer side is a valid/ready handshake.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          uart_rx,
  input  logic [2:0]                    baud_set,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          rx_busy,
  output logic                          frame_err,
  output logic                          overrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  // Oversample divider per rate, integer truncation of CLK_FREQ/(BAUD*16)
  localparam logic [15:0] DIV_9600   = 16'(CLK_FREQ / (9600 * 16));
  localparam logic [15:0] DIV_19200  = 16'(CLK_FREQ / (19200 * 16));
  localparam logic [15:0] DIV_38400  = 16'(CLK_FREQ / (38400 * 16));
  localparam logic [15:0] DIV_57600  = 16'(CLK_FREQ / (57600 * 16));
  localparam logic [15:0] DIV_115200 = 16'(CLK_FREQ / (115200 * 16));

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Synchronizer and edge-detect registers
  logic        sync1_q, sync2_q, prev_q;
  // Receive state and datapath
  state_t      state_q, state_d;
  logic [2:0]  baud_q, baud_d;
  logic [15:0] div_cnt_q, div_cnt_d;
  logic [3:0]  samp_cnt_q, samp_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  samp_q, samp_d;
  logic [7:0]  shift_q, shift_d;
  // FIFO storage and status
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic        frame_err_q, overrun_q;

  logic [15:0] div_sel_s;
  logic        tick_s, start_det_s, mid_s, end_s, maj_s;
  logic        push_req_s, fe_s, shift_en_s;
  logic        full_s, pop_s, push_s, ov_s;

  // Two-flop synchronizer (idle high) plus the previous-value register for edge detection
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= uart_rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Divider terminal count for the rate latched at the start of this frame
  always_comb begin
    div_sel_s = DIV_115200;
    case (baud_q)
      3'd0:    div_sel_s = DIV_9600;
      3'd1:    div_sel_s = DIV_19200;
      3'd2:    div_sel_s = DIV_38400;
      3'd3:    div_sel_s = DIV_57600;
      default: div_sel_s = DIV_115200;
    endcase
  end

  // Timing strobes: start edge, oversample tick, mid-bit vote point and end of bit
  always_comb begin
    start_det_s = (state_q == S_IDLE) && prev_q && !sync2_q;
    tick_s      = (state_q != S_IDLE) && (div_cnt_q == (div_sel_s - 16'd1));
    mid_s       = tick_s && (samp_cnt_q == 4'd9);
    end_s       = tick_s && (samp_cnt_q == 4'd15);
    maj_s       = majority3(samp_q[1], samp_q[0], sync2_q);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; STOP leaves at the vote so back-to-back frames keep half a bit of margin
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_det_s) state_d = S_START;
        else             state_d = S_IDLE;
      end
      S_START: begin
        if (mid_s && maj_s) state_d = S_IDLE;
        else if (end_s)     state_d = S_DATA;
        else                state_d = S_START;
      end
      S_DATA: begin
        if (end_s && (bit_cnt_q == 3'd7)) state_d = S_STOP;
        else                              state_d = S_DATA;
      end
      S_STOP: begin
        if (mid_s) state_d = S_IDLE;
        else       state_d = S_STOP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: data shift strobe and stop-bit verdicts
  always_comb begin
    shift_en_s = (state_q == S_DATA) && mid_s;
    push_req_s = (state_q == S_STOP) && mid_s && maj_s;
    fe_s       = (state_q == S_STOP) && mid_s && !maj_s;
  end

  // Next values for the divider, the sample/bit counters, the vote samples and the shift register
  always_comb begin
    baud_d = start_det_s ? baud_set : baud_q;

    if (start_det_s)             div_cnt_d = 16'd0;
    else if (state_q == S_IDLE)  div_cnt_d = 16'd0;
    else if (tick_s)             div_cnt_d = 16'd0;
    else                         div_cnt_d = div_cnt_q + 16'd1;

    if (start_det_s)  samp_cnt_d = 4'd0;
    else if (tick_s)  samp_cnt_d = samp_cnt_q + 4'd1;
    else              samp_cnt_d = samp_cnt_q;

    if (start_det_s)                          bit_cnt_d = 3'd0;
    else if ((state_q == S_DATA) && end_s)    bit_cnt_d = bit_cnt_q + 3'd1;
    else                                      bit_cnt_d = bit_cnt_q;

    if (tick_s && ((samp_cnt_q == 4'd7) || (samp_cnt_q == 4'd8)))
      samp_d = {samp_q[0], sync2_q};
    else
      samp_d = samp_q;

    if (start_det_s)     shift_d = 8'h00;
    else if (shift_en_s) shift_d = {maj_s, shift_q[7:1]};
    else                 shift_d = shift_q;
  end

  // Receive datapath registers; reset discards any partial byte
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      baud_q     <= 3'd0;
      div_cnt_q  <= 16'd0;
      samp_cnt_q <= 4'd0;
      bit_cnt_q  <= 3'd0;
      samp_q     <= 2'b11;
      shift_q    <= 8'h00;
    end else begin
      baud_q     <= baud_d;
      div_cnt_q  <= div_cnt_d;
      samp_cnt_q <= samp_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      samp_q     <= samp_d;
      shift_q    <= shift_d;
    end
  end

  // FIFO control; a pop in the same cycle frees the slot, so a push while full still succeeds
  always_comb begin
    full_s = (count_q == CW'(FIFO_DEPTH));
    pop_s  = (count_q != {CW{1'b0}}) && rx_ready;
    push_s = push_req_s && (!full_s || pop_s);
    ov_s   = push_req_s && full_s && !pop_s;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage, pointers, occupancy and the one-cycle status pulses
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      count_q     <= {CW{1'b0}};
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q     <= count_d;
      frame_err_q <= fe_s;
      overrun_q   <= ov_s;
    end
  end

  assign rx_data    = mem_q[rd_ptr_q];
  assign rx_valid   = (count_q != {CW{1'b0}});
  assign fifo_count = count_q;
  assign rx_busy    = (state_q != S_IDLE);
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed table of frames plus hand-written sequences for
// glitch, overrun, full push/pop, back-to-back and mid-frame reset.
module tb_uart_rx_fifo;

  localparam int CLK_FREQ   = 1_843_200;
  localparam int FIFO_DEPTH = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       uart_rx = 1'b1;
  logic [2:0] baud_set = 3'd0;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] fifo_count;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;

  uart_rx_fifo #(.CLK_FREQ(CLK_FREQ), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rstn(rstn), .uart_rx(uart_rx), .baud_set(baud_set),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .fifo_count(fifo_count), .rx_busy(rx_busy), .frame_err(frame_err),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int busy_cyc = 0;
  int vld_cyc = 0;
  logic [7:0] got_q [$];

  // Monitor on the falling edge: count pulses and log every byte handed to the consumer
  always @(negedge clk) begin
    if (rstn) begin
      if (frame_err) fe_cnt <= fe_cnt + 1;
      if (overrun)   ov_cnt <= ov_cnt + 1;
      if (rx_busy)   busy_cyc <= busy_cyc + 1;
      if (rx_valid)  vld_cyc <= vld_cyc + 1;
      if (rx_valid && rx_ready) got_q.push_back(rx_data);
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] data;
    logic [2:0] baud;
    logic       stop;
    int         exp_fe;
    int         exp_n;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int div);
    uart_rx = b;
    wait_clk(16 * div);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int div);
    send_bit(1'b0, div);
    for (int i = 0; i < 8; i++) send_bit(d[i], div);
    send_bit(stop, div);
  endtask

  function automatic int div_of(input logic [2:0] b);
    case (b)
      3'd0:    return 12;
      3'd1:    return 6;
      3'd2:    return 3;
      3'd3:    return 2;
      default: return 1;
    endcase
  endfunction

  int fe0, ov0, n0, vld0, busy0, d;

  initial begin
    vecs[0] = '{8'h99, 3'd0, 1'b1, 0, 1, 8'h99};
    vecs[1] = '{8'h55, 3'd0, 1'b0, 1, 0, 8'h00};
    vecs[2] = '{8'hAA, 3'd0, 1'b1, 0, 1, 8'hAA};
    vecs[3] = '{8'h00, 3'd1, 1'b1, 0, 1, 8'h00};
    vecs[4] = '{8'hFF, 3'd2, 1'b1, 0, 1, 8'hFF};
    vecs[5] = '{8'h5A, 3'd3, 1'b1, 0, 1, 8'h5A};
    vecs[6] = '{8'hC3, 3'd7, 1'b1, 0, 1, 8'hC3};

    // Reset values
    wait_clk(3);
    check("rst_rx_data", int'(rx_data), 0);
    check("rst_rx_valid", int'(rx_valid), 0);
    check("rst_fifo_count", int'(fifo_count), 0);
    check("rst_rx_busy", int'(rx_busy), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_overrun", int'(overrun), 0);
    rstn = 1'b1;
    wait_clk(5);

    // Table: single frames at every rate, including a low stop bit then a good frame
    for (int i = 0; i < 7; i++) begin
      baud_set = vecs[i].baud;
      fe0 = fe_cnt; ov0 = ov_cnt; n0 = got_q.size(); vld0 = vld_cyc;
      send_frame(vecs[i].data, vecs[i].stop, div_of(vecs[i].baud));
      uart_rx = 1'b1;
      wait_clk(16 * div_of(vecs[i].baud) + 10);
      check($sformatf("vec%0d_frame_err", i), fe_cnt - fe0, vecs[i].exp_fe);
      check($sformatf("vec%0d_overrun", i), ov_cnt - ov0, 0);
      check($sformatf("vec%0d_pops", i), got_q.size() - n0, vecs[i].exp_n);
      check($sformatf("vec%0d_valid_cycles", i), vld_cyc - vld0, vecs[i].exp_n);
      if (vecs[i].exp_n == 1 && got_q.size() > n0)
        check($sformatf("vec%0d_data", i), int'(got_q[n0]), int'(vecs[i].exp_data));
      check($sformatf("vec%0d_count", i), int'(fifo_count), 0);
      check($sformatf("vec%0d_busy", i), int'(rx_busy), 0);
    end

    // Glitch: line low for 3*DIV clocks at 9600 is a false start
    baud_set = 3'd0;
    fe0 = fe_cnt; ov0 = ov_cnt; n0 = got_q.size(); busy0 = busy_cyc;
    uart_rx = 1'b0;
    wait_clk(36);
    uart_rx = 1'b1;
    wait_clk(16 * 12 * 2);
    d = busy_cyc - busy0;
    check("glitch_busy_about_10div", int'(d >= 116 && d <= 124), 1);
    check("glitch_frame_err", fe_cnt - fe0, 0);
    check("glitch_overrun", ov_cnt - ov0, 0);
    check("glitch_pops", got_q.size() - n0, 0);
    check("glitch_count", int'(fifo_count), 0);

    // Overrun: five bytes into a stalled four-entry FIFO
    rx_ready = 1'b0;
    fe0 = fe_cnt; ov0 = ov_cnt; n0 = got_q.size();
    for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1, 12);
    uart_rx = 1'b1;
    wait_clk(16 * 12);
    check("ovr_count_full", int'(fifo_count), 4);
    check("ovr_pulses", ov_cnt - ov0, 1);
    check("ovr_frame_err", fe_cnt - fe0, 0);
    rx_ready = 1'b1;
    wait_clk(10);
    check("ovr_drained", got_q.size() - n0, 4);
    for (int k = 0; k < 4; k++)
      if (got_q.size() > n0 + k)
        check($sformatf("ovr_order%0d", k), int'(got_q[n0 + k]), k + 1);
    check("ovr_count_empty", int'(fifo_count), 0);

    // Back-to-back frames at DIV=1 with no idle gap
    baud_set = 3'd4;
    fe0 = fe_cnt; ov0 = ov_cnt; n0 = got_q.size();
    send_frame(8'hA5, 1'b1, 1);
    send_frame(8'h3C, 1'b1, 1);
    uart_rx = 1'b1;
    wait_clk(40);
    check("b2b_pops", got_q.size() - n0, 2);
    if (got_q.size() >= n0 + 2) begin
      check("b2b_first", int'(got_q[n0]), 8'hA5);
      check("b2b_second", int'(got_q[n0 + 1]), 8'h3C);
    end
    check("b2b_frame_err", fe_cnt - fe0, 0);
    check("b2b_overrun", ov_cnt - ov0, 0);

    // Push and pop in the same cycle while full: stop decision lands 157 clocks after the start bit is driven
    rx_ready = 1'b0;
    for (int b = 1; b <= 4; b++) send_frame(8'(8'h11 * b), 1'b1, 1);
    uart_rx = 1'b1;
    wait_clk(40);
    check("pp_prefill_count", int'(fifo_count), 4);
    fe0 = fe_cnt; ov0 = ov_cnt; n0 = got_q.size();
    fork
      send_frame(8'h55, 1'b1, 1);
      begin
        wait_clk(156);
        rx_ready = 1'b1;
        check("pp_count_before", int'(fifo_count), 4);
        wait_clk(1);
        rx_ready = 1'b0;
        check("pp_count_after", int'(fifo_count), 4);
      end
    join
    uart_rx = 1'b1;
    wait_clk(40);
    check("pp_overrun", ov_cnt - ov0, 0);
    check("pp_single_pop", got_q.size() - n0, 1);
    check("pp_count_held", int'(fifo_count), 4);
    rx_ready = 1'b1;
    wait_clk(10);
    check("pp_drain", got_q.size() - n0, 5);
    if (got_q.size() >= n0 + 5) begin
      check("pp_order0", int'(got_q[n0]), 8'h11);
      check("pp_order1", int'(got_q[n0 + 1]), 8'h22);
      check("pp_order4", int'(got_q[n0 + 4]), 8'h55);
    end

    // Reset in the middle of DATA bit 4 with one byte already buffered
    baud_set = 3'd0;
    rx_ready = 1'b0;
    send_frame(8'h3C, 1'b1, 12);
    uart_rx = 1'b1;
    wait_clk(16 * 12);
    check("mid_prefill_count", int'(fifo_count), 1);
    send_bit(1'b0, 12);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 12);
    uart_rx = 1'b1;
    wait_clk(8 * 12);
    check("mid_busy_before", int'(rx_busy), 1);
    rstn = 1'b0;
    wait_clk(2);
    check("mid_rx_data", int'(rx_data), 0);
    check("mid_rx_valid", int'(rx_valid), 0);
    check("mid_count", int'(fifo_count), 0);
    check("mid_busy", int'(rx_busy), 0);
    check("mid_frame_err", int'(frame_err), 0);
    check("mid_overrun", int'(overrun), 0);
    rstn = 1'b1;
    wait_clk(20);
    rx_ready = 1'b1;
    fe0 = fe_cnt; ov0 = ov_cnt; n0 = got_q.size();
    send_frame(8'h0F, 1'b1, 12);
    uart_rx = 1'b1;
    wait_clk(16 * 12 + 10);
    check("post_rst_pops", got_q.size() - n0, 1);
    if (got_q.size() > n0) check("post_rst_data", int'(got_q[n0]), 8'h0F);
    check("post_rst_frame_err", fe_cnt - fe0, 0);
    check("post_rst_overrun", ov_cnt - ov0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

- Oversampling UART receiver that recovers 8N1 bytes from a serial line and buffers them in a small first-word-fall-through (FWFT) FIFO.
- Consumer side uses a valid/ready handshake.
- Pairs with `uart_byte_tx` as the far-end receiver of its `baud_set` rate table.
- Differs from `uart_byte_rx`: adds glitch rejection, framing-error and overrun reporting, and buffering for back-pressured consumers.

## Interface

Parameters:
- CLK_FREQ, 50_000_000: clk frequency in Hz.
- FIFO_DEPTH, 4: FIFO entries; power of 2, minimum 2.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset. One clock domain; reset is asynchronous and active-low.
- uart_rx  in  1  serial input, asynchronous, idles high.
- baud_set  in  3  rate select: 0=9600, 1=19200, 2=38400, 3=57600, 4–7=115200.
- rx_data  out  8  FIFO head byte, valid when rx_valid=1.
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  consumer accepts the head byte; pop occurs when rx_valid&rx_ready.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of entries held.
- rx_busy  out  1  receive state machine not IDLE.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: completed byte dropped because FIFO full.

## Operation

- **Input synchronizer:** uart_rx passes through a 2-flop synchronizer; both flops reset to 1. A start is detected on a synchronized 1→0 edge while in IDLE.
- **Rate selection:** baud_set is latched at start detection. Changes during a frame take effect on the next frame.
- **Oversample divider:** DIV = CLK_FREQ/(BAUD*16), integer truncation.
  - A divider counter runs 0..DIV-1 and emits one oversample tick when it reaches DIV-1.
  - It is cleared to 0 at start detection and held at 0 in IDLE.
- **Sampling:** a 4-bit sample counter runs 0..15 per bit period. Samples are taken at ticks 7, 8, 9; the bit value is the 2-of-3 majority.
- **State machine:** IDLE → START → DATA → STOP → IDLE.
  - IDLE: wait for the falling edge.
  - START: if the majority is 1, the start is false; return to IDLE immediately after tick 9 with no flags. Otherwise advance to DATA after tick 15.
  - DATA: 8 bits, LSB first, shifted into a byte register. Advance to STOP after tick 15 of bit 7.
  - STOP: decide after tick 9 and return to IDLE that same cycle. Returning at tick 9 gives half-bit resync margin for back-to-back frames.
    - Majority 1 and FIFO not full: push the byte.
    - Majority 1 and FIFO full, with no pop in the same cycle: drop the byte and pulse overrun.
    - Majority 0: pulse frame_err and push nothing.
- **FIFO:** FWFT. rx_data = mem[rd_ptr]. Pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop while full: both succeed, count unchanged, no overrun.
  - Simultaneous push and pop while empty: push only; the pop is not qualified because rx_valid=0.
- **Reset:** asynchronous. Any state, including mid-frame, returns to IDLE. The partial byte is discarded and the FIFO is emptied.

## Timing

- **Reset values:**
  - rx_data 8'h00, rx_valid 0, fifo_count 0, rx_busy 0, frame_err 0, overrun 0.
  - Internal state IDLE; synchronizer flops at 1.
- **Start detection:** rx_busy rises 3 clk after uart_rx falls (2 synchronizer flops plus edge register).
- **Write latency:** rx_valid and the updated fifo_count are visible the clk after the STOP tick-9 decision. frame_err and overrun pulse in that same cycle.
- **Pop:** fifo_count decrements and rx_data advances the clk after the valid&ready edge.
- **rx_busy:** falls in the same cycle as the STOP decision or the false-start abort.
- **Frame duration:** from start detection to STOP decision is (16*9+10)*DIV clk, ±1 clk.

## Test plan

1. **Single byte:** CLK_FREQ=1_843_200, baud_set=0 (DIV=12), rx_ready=1, uart_byte_tx sends 8'h99 → exactly one rx_valid cycle with rx_data=8'h99, frame_err=0, overrun=0, fifo_count returns to 0.
2. **Glitch rejection:** uart_rx low for 3*DIV clk, then high → no push, no flags, rx_busy high for about 10*DIV clk then low.
3. **Framing error:** 8'h55 sent with the stop bit forced low → one frame_err pulse, fifo_count stays 0. The following good frame 8'hAA is received correctly.
4. **Overrun:** rx_ready=0, send 8'h01..8'h05 → fifo_count=4, one overrun pulse on the 5th byte. Raising rx_ready then pops 01, 02, 03, 04 in order.
5. **Back-to-back at speed:** baud_set=4 (DIV=1), 8'hA5 then 8'h3C with no idle gap between frames → both received in order, no errors. A simultaneous push and pop while full leaves fifo_count unchanged.
6. **Reset mid-frame:** assert rstn=0 during DATA bit 4 → all outputs at reset values. After release the next frame 8'h0F is received cleanly.
